// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a credit-limited request port,
// an in-flight address queue and a DEPTH-entry instruction buffer.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   pc / next_pc / pc_enable        external PC register interface
//   imem_req_valid/ready/addr       fetch request channel (addr == pc)
//   imem_resp_valid/data            in-order response channel, no backpressure
//   redirect_valid/target           branch/jump redirect pulse
//   if_valid/ready/instr/pc         buffered instruction towards decode
module fetch_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_enable,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;

  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] aq_mem_q    [DEPTH];

  logic resp_live, credit_ok, req_ok, accept, push, pop;
  logic unused_tgt_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request/PC side; outputs are forced idle while reset is held.
  assign resp_live      = imem_resp_valid && (inflight_q != '0);
  assign credit_ok      = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
  assign req_ok         = (state_q == ST_FETCH) && !redirect_valid && credit_ok;
  assign accept         = req_ok && imem_req_ready;
  assign imem_req_valid = reset_n && req_ok;
  assign pc_enable      = reset_n && (redirect_valid || accept);
  assign next_pc        = redirect_valid ? {redirect_target[31:2], 2'b00} : pc + 32'd4;
  assign imem_addr      = pc;
  assign unused_tgt_lsb = ^redirect_target[1:0];

  // Decode side reads only registered buffer state.
  assign if_valid = (count_q != '0);
  assign if_instr = buf_instr_q[head_q];
  assign if_pc    = buf_pc_q[head_q];

  // Next-state logic for FSM, occupancy counters and queue pointers.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    aq_wr_d    = aq_wr_q;
    aq_rd_d    = aq_rd_q;
    push       = 1'b0;
    pop        = 1'b0;
    inflight_d = inflight_q + CW'(accept) - CW'(resp_live);

    if (accept)    aq_wr_d = ptr_inc(aq_wr_q);
    if (resp_live) aq_rd_d = ptr_inc(aq_rd_q);

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          // Everything still in flight belongs to the old path.
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          drop_d  = inflight_q - CW'(resp_live);
          state_d = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
          push = resp_live;
          pop  = if_valid && if_ready;
          if (push) tail_d = ptr_inc(tail_q);
          if (pop)  head_d = ptr_inc(head_q);
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
      ST_FLUSH: begin
        if (redirect_valid) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end
        if (resp_live) drop_d = drop_q - CW'(1);
        state_d = (drop_d == '0) ? ST_FETCH : ST_FLUSH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FETCH;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
    end
  end

  // Data storage; contents are qualified by the pointers/counters above.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[tail_q] <= imem_resp_data;
      buf_pc_q[tail_q]    <= aq_mem_q[aq_rd_q];
    end
    if (accept) aq_mem_q[aq_wr_q] <= imem_addr;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (DEPTH=2) with a PC register
// model, a memory model returning responses one cycle after acceptance, and a
// scoreboard of expected {pc, instr} deliveries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_enable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc              (pc),
    .next_pc         (next_pc),
    .pc_enable       (pc_enable),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] epoch; } mreq_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] instr; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_acc = 0;
  int          n_deliv = 0;
  int          d0;
  logic [31:0] epoch = 32'd0;
  logic [31:0] next_deliv_pc = 32'd0;
  bit          mem_en = 1'b0;
  bit          spur = 1'b0;
  bit          found;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'hC3A5_0F1E) + 32'h0000_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drive this cycle's memory response, then let combinational outputs settle.
  task automatic present();
    if (spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0BAD;
    end else if (mem_en && mem_q.size() != 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #2;
  endtask

  // Check/score this cycle, clock it, and update the PC register model.
  task automatic advance();
    logic        red, acc, pe;
    logic [31:0] npc, tgt;
    mreq_t       m;
    exp_t        e;
    red = redirect_valid;
    acc = imem_req_valid && imem_req_ready;
    pe  = pc_enable;
    npc = next_pc;
    tgt = {redirect_target[31:2], 2'b00};
    if (imem_req_valid) chk("imem_addr", imem_addr, pc);
    chk("pc_enable", 32'(pe), 32'(red || acc));
    if (pe) chk("next_pc", npc, red ? tgt : pc + 32'd4);
    if (if_valid && if_ready && !red) begin
      chk("deliv_expected", 32'(exp_q.size() != 0), 32'd1);
      chk("deliv_pc_order", if_pc, next_deliv_pc);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliv_pc", if_pc, e.pc);
        chk("deliv_instr", if_instr, e.instr);
      end
      next_deliv_pc = next_deliv_pc + 32'd4;
      n_deliv++;
    end
    if (imem_resp_valid && !spur) begin
      m = mem_q.pop_front();
      if (!red && m.epoch == epoch) begin
        e.pc    = m.addr;
        e.instr = instr_of(m.addr);
        exp_q.push_back(e);
      end
    end
    if (red) begin
      epoch++;
      exp_q.delete();
      next_deliv_pc = tgt;
    end
    if (acc) begin
      m.addr  = pc;
      m.epoch = epoch;
      mem_q.push_back(m);
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (pe) pc = npc;
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    mem_en         = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    repeat (6) begin present(); advance(); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n         = 1'b0;
    pc              = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    if_ready        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_enable", 32'(pc_enable), 32'd0);
    redirect_valid = 1'b0;
    reset_n        = 1'b1;

    // Streaming from pc=0.
    mem_en = 1'b1;
    repeat (20) begin present(); advance(); end
    chk("stream_progress", 32'(n_deliv >= 8), 32'd1);

    // Backpressure: restart at 0 with decode stalled.
    drain();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    present(); advance();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    n_acc          = 0;
    repeat (6) begin present(); advance(); end
    present();
    chk("bp_accepts", 32'(n_acc), 32'd2);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_pc_enable", 32'(pc_enable), 32'd0);
    chk("bp_pc_hold", pc, 32'h8);
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    chk("bp_head_pc", if_pc, 32'h0);
    chk("bp_head_instr", if_instr, instr_of(32'h0));
    advance();
    if_ready = 1'b1;
    repeat (8) begin present(); advance(); end

    // Redirect with two requests in flight.
    drain();
    mem_en         = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) begin present(); advance(); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    present();
    chk("redir_next_pc", next_pc, 32'h100);
    chk("redir_pc_enable", 32'(pc_enable), 32'd1);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    advance();
    redirect_valid = 1'b0;
    mem_en         = 1'b1;
    present();
    chk("flush_hold_1", 32'(imem_req_valid), 32'd0);
    advance();
    present();
    chk("flush_hold_2", 32'(imem_req_valid), 32'd0);
    advance();
    present();
    chk("refetch_valid", 32'(imem_req_valid), 32'd1);
    chk("refetch_addr", imem_addr, 32'h100);
    advance();
    d0 = n_deliv;
    for (int i = 0; i < 10 && n_deliv == d0; i++) begin present(); advance(); end
    chk("redir_delivered", 32'(n_deliv != d0), 32'd1);

    // Redirect coincident with a response and a decode pop.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      present();
      if (imem_resp_valid && if_valid) begin
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        found = 1'b1;
      end
      advance();
      redirect_valid = 1'b0;
    end
    chk("coincide_found", 32'(found), 32'd1);
    present();
    chk("coincide_empty", 32'(if_valid), 32'd0);
    advance();
    d0 = n_deliv;
    repeat (10) begin present(); advance(); end
    chk("coincide_resume", 32'(n_deliv > d0), 32'd1);

    // PC wrap at the top of the address space.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    present(); advance();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      present();
      if (imem_req_valid && imem_req_ready && pc == 32'hFFFF_FFFC) begin
        chk("wrap_next_pc", next_pc, 32'h0);
        found = 1'b1;
      end
      advance();
    end
    chk("wrap_found", 32'(found), 32'd1);
    repeat (8) begin present(); advance(); end

    // Response with nothing in flight is ignored.
    drain();
    present();
    chk("idle_empty", 32'(if_valid), 32'd0);
    advance();
    spur = 1'b1;
    present(); advance();
    spur = 1'b0;
    present();
    chk("spur_ignored", 32'(if_valid), 32'd0);
    advance();

    // Async reset in the middle of a flush.
    mem_en         = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) begin present(); advance(); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    present(); advance();
    redirect_valid = 1'b0;
    present();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_pc_enable", 32'(pc_enable), 32'd0);
    mem_q.delete();
    exp_q.delete();
    epoch++;
    pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_n       = 1'b1;
    next_deliv_pc = 32'h0;
    mem_en        = 1'b1;
    spur          = 1'b1;
    present(); advance();
    spur = 1'b0;
    d0 = n_deliv;
    repeat (12) begin present(); advance(); end
    chk("post_rst_progress", 32'(n_deliv - d0 >= 4), 32'd1);

    drain();
    present();
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_if_valid", 32'(if_valid), 32'd0);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
